gpio_msg_receiver: RTL

Receive-side endpoint of the inter-FPGA GPIO message link. It samples the 32-bit shared data lines on the link clock, assembles four beats into a 128-bit message, and checks the sender's done strobe. Good messages go into a one-entry holding register with a valid/ready handshake to the local core, and the block pulses an acknowledge line back to the peer. It sits between the GPIO pin mux (tri-state split already done upstream) and the core's message consumer.

---
 rtl/gpio_proto_pkg.sv | 24 ++
 rtl/gpio_msg_receiver_if.sv | 33 +++
 rtl/gpio_rx_holding.sv | 45 ++++
 rtl/gpio_msg_receiver.sv | 113 +++++++++++
 4 files changed

// File: rtl/gpio_proto_pkg.sv
// Shared definitions for the inter-FPGA GPIO message link (receive and transmit sides).
package gpio_proto_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned MSG_W  = DATA_W * BEATS;
  localparam int unsigned CNT_W  = 16;

  // Bit positions on the shared GPIO bank
  localparam int unsigned GpioDataLsb     = 0;
  localparam int unsigned GpioDataMsb     = 31;
  localparam int unsigned GpioClkBit      = 32;
  localparam int unsigned GpioDoneBit     = 33;
  localparam int unsigned GpioReadyBit    = 34;
  localparam int unsigned GpioReadyAltBit = 35;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDoneChk,
    StGap
  } rx_state_e;

endpackage

// File: rtl/gpio_msg_receiver_if.sv
// Signal bundle between the GPIO pins / local core and the message receiver.
interface gpio_msg_receiver_if
  import gpio_proto_pkg::*;
#(
  parameter int unsigned DATA_W = gpio_proto_pkg::DATA_W,
  parameter int unsigned BEATS  = gpio_proto_pkg::BEATS,
  parameter int unsigned CNT_W  = gpio_proto_pkg::CNT_W
);

  logic [DATA_W-1:0]       gpio_data;
  logic                    peer_ready;
  logic                    peer_done;
  logic [DATA_W*BEATS-1:0] message_in;
  logic                    msg_valid;
  logic                    msg_ready;
  logic                    ack_out;
  logic                    abort_err;
  logic                    frame_err;
  logic                    overflow;
  logic [CNT_W-1:0]        msg_count;

  // Peer pins plus the consuming core
  modport master (
    output gpio_data, peer_ready, peer_done, msg_ready,
    input  message_in, msg_valid, ack_out, abort_err, frame_err, overflow, msg_count
  );

  modport slave (
    input  gpio_data, peer_ready, peer_done, msg_ready,
    output message_in, msg_valid, ack_out, abort_err, frame_err, overflow, msg_count
  );

endinterface

// File: rtl/gpio_rx_holding.sv
// One-entry message holding register with valid/ready drain and sticky overflow.
module gpio_rx_holding #(
  parameter int unsigned W = 128
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overflow,
  output logic         accept
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         overflow_q;

  // A slot freed by a same-cycle consume can take the new message
  assign accept = load & (~valid_q | ready);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q  <= load_data;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (load && !accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/gpio_msg_receiver.sv
// Receive endpoint: assembles BEATS GPIO beats into a message, checks done, hands it to the core.
module gpio_msg_receiver
  import gpio_proto_pkg::*;
#(
  parameter int unsigned DATA_W = gpio_proto_pkg::DATA_W,
  parameter int unsigned BEATS  = gpio_proto_pkg::BEATS,
  parameter int unsigned CNT_W  = gpio_proto_pkg::CNT_W
) (
  input logic               clock,
  input logic               resetn,
  gpio_msg_receiver_if.slave bus
);

  localparam int unsigned MsgW = DATA_W * BEATS;
  localparam int unsigned IdxW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);

  rx_state_e        state_q, state_d;
  logic [IdxW-1:0]  cnt_q, cnt_d;
  logic [MsgW-1:0]  beats_q, beats_d;
  logic             abort_q, abort_d;
  logic             frame_q, frame_d;
  logic             ack_q;
  logic [CNT_W-1:0] msg_count_q;
  logic             commit;
  logic             accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    abort_d = 1'b0;
    frame_d = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.peer_ready) begin
          beats_d[DATA_W-1:0] = bus.gpio_data;
          cnt_d               = IdxW'(1);
          state_d             = StRecv;
        end
      end
      StRecv: begin
        if (bus.peer_ready) begin
          beats_d[int'(cnt_q)*DATA_W +: DATA_W] = bus.gpio_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StDoneChk;
          end
        end else begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StDoneChk: begin
        commit  = bus.peer_done;
        frame_d = ~bus.peer_done;
        cnt_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        // Peer must release ready before the next message can start
        if (!bus.peer_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      beats_q     <= '0;
      abort_q     <= 1'b0;
      frame_q     <= 1'b0;
      ack_q       <= 1'b0;
      msg_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      abort_q <= abort_d;
      frame_q <= frame_d;
      ack_q   <= accept;
      if (accept) begin
        msg_count_q <= msg_count_q + 1'b1;
      end
    end
  end

  gpio_rx_holding #(
    .W(MsgW)
  ) u_holding (
    .clock     (clock),
    .resetn    (resetn),
    .load      (commit),
    .load_data (beats_q),
    .ready     (bus.msg_ready),
    .data      (bus.message_in),
    .valid     (bus.msg_valid),
    .overflow  (bus.overflow),
    .accept    (accept)
  );

  assign bus.ack_out   = ack_q;
  assign bus.abort_err = abort_q;
  assign bus.frame_err = frame_q;
  assign bus.msg_count = msg_count_q;

endmodule
